// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demux sequencer.
//  NUM_CH      : channels per frame (fixed at 8)
//  SEL_W       : demux select width
//  GAP_W       : width of the inter-frame gap counter (0..15 cycles)
//  seq_state_t : sequencer FSM states
//  is_last_chan: true when the given channel is the final channel of a frame
package tdm_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    function automatic logic is_last_chan(input logic [SEL_W-1:0] chan);
        return (chan == SEL_W'(NUM_CH - 1));
    endfunction

endpackage

// File: rtl/tdm_gap_timer.sv
// Down-counter that times the dead cycles after each frame.
//  clk      in  clock, rising edge
//  rst_n    in  synchronous reset, active-low (count cleared)
//  load     in  load load_val into the counter
//  load_val in  number of gap cycles to time
//  dec      in  count down by one (ignored while load is high)
//  done     out counter is on its final gap cycle (count <= 1)
module tdm_gap_timer
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [GAP_W-1:0] cnt_d;
    logic [GAP_W-1:0] cnt_q;

    // Next-count logic: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {GAP_W{1'b0}})) begin
            cnt_d = cnt_q - GAP_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {GAP_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The GAP state is left when the count shows its last cycle.
    assign done = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/tdm_demux_sequencer.sv
// Serial TDM front end for a 1-to-8 demux: each accepted frame bit is
// presented on din with its channel number on {s2,s1,s0}, one cycle after
// the accepting edge. Reports frame completion, mid-frame SOF and drops.
//  clk, rst_n         : clock and synchronous active-low reset
//  in_valid/in_ready  : input handshake, accept = in_valid & in_ready
//  in_data, in_sof    : serial bit and start-of-frame marker
//  din, s0..s2        : registered demux data and select
//  frame_done         : pulse while channel 7 is on the demux
//  sof_err            : pulse while the restarted channel-0 bit is on the demux
//  drop               : pulse after a bit was discarded in IDLE
module tdm_demux_sequencer
    import tdm_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_data,
    input  logic in_sof,
    output logic in_ready,
    output logic din,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic frame_done,
    output logic sof_err,
    output logic drop
);

    seq_state_t       state_d, state_q;
    logic [SEL_W-1:0] chan_d, chan_q;
    logic [SEL_W-1:0] sel_d, sel_q;
    logic             din_d, din_q;
    logic             ready_d, ready_q;
    logic             frame_done_d, frame_done_q;
    logic             sof_err_d, sof_err_q;
    logic             drop_d, drop_q;
    logic             gap_load_s;
    logic             gap_dec_s;
    logic             gap_done_s;
    logic             accept_s;

    assign accept_s = in_valid & ready_q;

    tdm_gap_timer u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load_s),
        .load_val (GAP_W'(GAP_CYCLES)),
        .dec      (gap_dec_s),
        .done     (gap_done_s)
    );

    // Next-state and output decode; din defaults to 0 so stalls and gaps
    // leave the demux outputs quiet while selects hold.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        sel_d        = sel_q;
        din_d        = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        drop_d       = 1'b0;
        gap_load_s   = 1'b0;
        gap_dec_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s && in_sof) begin
                    din_d   = in_data;
                    sel_d   = {SEL_W{1'b0}};
                    chan_d  = SEL_W'(1);
                    state_d = RUN;
                end else if (accept_s) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s && in_sof) begin
                    // Mid-frame SOF: abandon the frame and restart at channel 0.
                    sof_err_d = 1'b1;
                    din_d     = in_data;
                    sel_d     = {SEL_W{1'b0}};
                    chan_d    = SEL_W'(1);
                end else if (accept_s) begin
                    din_d = in_data;
                    sel_d = chan_q;
                    if (is_last_chan(chan_q)) begin
                        frame_done_d = 1'b1;
                        chan_d       = {SEL_W{1'b0}};
                        if (GAP_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = GAP;
                            gap_load_s = 1'b1;
                        end
                    end else begin
                        chan_d = chan_q + SEL_W'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            GAP: begin
                gap_dec_s = 1'b1;
                if (gap_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = {SEL_W{1'b0}};
            end
        endcase
        // in_ready is registered from the upcoming state.
        ready_d = (state_d != GAP);
    end

    // State, channel and registered output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            chan_q       <= {SEL_W{1'b0}};
            sel_q        <= {SEL_W{1'b0}};
            din_q        <= 1'b0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            sel_q        <= sel_d;
            din_q        <= din_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            drop_q       <= drop_d;
        end
    end

    assign in_ready   = ready_q;
    assign din        = din_q;
    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign s2         = sel_q[2];
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_tdm_demux_sequencer.sv
// Directed bench for tdm_demux_sequencer: default gap instance for the
// main scenarios, plus GAP_CYCLES=0 and GAP_CYCLES=3 instances for the
// back-to-back frame scenario.
module tb_tdm_demux_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_data, in_sof;
    logic in_ready, din, s0, s1, s2, frame_done, sof_err, drop;
    logic v0, d0, f0, r0, dn0, a0, b0, c0, fd0_o, se0, dr0;
    logic v3, d3, f3, r3, dn3, a3, b3, c3, fd3_o, se3, dr3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tdm_demux_sequencer #(.GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_ready(in_ready), .din(din), .s0(s0), .s1(s1),
        .s2(s2), .frame_done(frame_done), .sof_err(sof_err), .drop(drop)
    );

    tdm_demux_sequencer #(.GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0),
        .in_sof(f0), .in_ready(r0), .din(dn0), .s0(a0), .s1(b0),
        .s2(c0), .frame_done(fd0_o), .sof_err(se0), .drop(dr0)
    );

    tdm_demux_sequencer #(.GAP_CYCLES(3)) u_g3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
        .in_sof(f3), .in_ready(r3), .din(dn3), .s0(a3), .s1(b3),
        .s2(c3), .frame_done(fd3_o), .sof_err(se3), .drop(dr3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic data, input logic sof);
        in_valid = 1'b1;
        in_data  = data;
        in_sof   = sof;
        step();
        in_valid = 1'b0;
        in_data  = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        logic [7:0] p1;
        logic [7:0] p2;
        logic [15:0] pat;
        int fd;
        int k0, k3, low0, low3, fd0, fd3;
        logic acc0, acc3;

        p1  = 8'b0100_1101;   // ch0..ch7 = 1,0,1,1,0,0,1,0
        p2  = 8'b1001_0110;   // ch0..ch7 = 0,1,1,0,1,0,0,1
        pat = 16'hA5C3;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 1'b0; in_sof = 1'b0;
        v0 = 1'b0; d0 = 1'b0; f0 = 1'b0;
        v3 = 1'b0; d3 = 1'b0; f3 = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_din", {7'd0, din}, 8'd0);
        chk("rst_sel", {5'd0, s2, s1, s0}, 8'd0);
        chk("rst_pulses", {5'd0, frame_done, sof_err, drop}, 8'd0);
        chk("rst_ready", {7'd0, in_ready}, 8'd1);
        rst_n = 1'b1;
        step();

        // 1: frame 10110010, back-to-back
        for (int i = 0; i < 8; i++) begin
            chk("t1_ready_pre", {7'd0, in_ready}, 8'd1);
            send(p1[i], (i == 0));
            chk("t1_din", {7'd0, din}, {7'd0, p1[i]});
            chk("t1_sel", {5'd0, s2, s1, s0}, 8'(i));
            chk("t1_fdone", {7'd0, frame_done}, (i == 7) ? 8'd1 : 8'd0);
            chk("t1_sof_err", {7'd0, sof_err}, 8'd0);
        end
        chk("t1_gap_ready", {7'd0, in_ready}, 8'd0);
        step();
        chk("t1_ready_back", {7'd0, in_ready}, 8'd1);
        chk("t1_gap_din", {7'd0, din}, 8'd0);
        chk("t1_gap_sel_hold", {5'd0, s2, s1, s0}, 8'd7);
        chk("t1_fdone_single", {7'd0, frame_done}, 8'd0);

        // 2: stall of 3 cycles after ch3
        fd = 0;
        for (int i = 0; i < 4; i++) begin
            send(p2[i], (i == 0));
            chk("t2_sel_a", {5'd0, s2, s1, s0}, 8'(i));
            chk("t2_din_a", {7'd0, din}, {7'd0, p2[i]});
            fd += int'(frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_sel", {5'd0, s2, s1, s0}, 8'd3);
            chk("t2_stall_din", {7'd0, din}, 8'd0);
            fd += int'(frame_done);
        end
        for (int i = 4; i < 8; i++) begin
            send(p2[i], 1'b0);
            chk("t2_sel_b", {5'd0, s2, s1, s0}, 8'(i));
            chk("t2_din_b", {7'd0, din}, {7'd0, p2[i]});
            fd += int'(frame_done);
        end
        step();
        fd += int'(frame_done);
        chk("t2_fdone_count", 8'(fd), 8'd1);

        // 3: SOF reasserted at bit 5
        fd = 0;
        for (int i = 0; i < 5; i++) begin
            send(p1[i], (i == 0));
            fd += int'(frame_done);
        end
        send(1'b1, 1'b1);
        chk("t3_sof_err", {7'd0, sof_err}, 8'd1);
        chk("t3_restart_sel", {5'd0, s2, s1, s0}, 8'd0);
        chk("t3_restart_din", {7'd0, din}, 8'd1);
        chk("t3_no_fdone", {7'd0, frame_done}, 8'd0);
        for (int j = 1; j < 8; j++) begin
            send(p2[j], 1'b0);
            chk("t3_sel", {5'd0, s2, s1, s0}, 8'(j));
            chk("t3_sof_err_clr", {7'd0, sof_err}, 8'd0);
            fd += int'(frame_done);
        end
        chk("t3_last_fdone", {7'd0, frame_done}, 8'd1);
        step();
        chk("t3_fdone_count", 8'(fd), 8'd1);

        // 4: data without SOF while IDLE
        send(1'b1, 1'b0);
        chk("t4_drop", {7'd0, drop}, 8'd1);
        chk("t4_din", {7'd0, din}, 8'd0);
        chk("t4_ready", {7'd0, in_ready}, 8'd1);
        step();
        chk("t4_drop_clr", {7'd0, drop}, 8'd0);
        // Still IDLE: an SOF bit starts cleanly with no sof_err
        send(1'b1, 1'b1);
        chk("t4_idle_sof_sel", {5'd0, s2, s1, s0}, 8'd0);
        chk("t4_idle_sof_err", {7'd0, sof_err}, 8'd0);

        // 5: reset asserted at ch4
        for (int i = 1; i < 4; i++) begin
            send(1'b1, 1'b0);
        end
        chk("t5_pre_sel", {5'd0, s2, s1, s0}, 8'd3);
        rst_n = 1'b0;
        send(1'b1, 1'b0);
        rst_n = 1'b1;
        chk("t5_rst_din", {7'd0, din}, 8'd0);
        chk("t5_rst_sel", {5'd0, s2, s1, s0}, 8'd0);
        chk("t5_rst_pulses", {5'd0, frame_done, sof_err, drop}, 8'd0);
        fd = 0;
        for (int i = 0; i < 8; i++) begin
            send(p1[i], (i == 0));
            chk("t5_sel", {5'd0, s2, s1, s0}, 8'(i));
            chk("t5_din", {7'd0, din}, {7'd0, p1[i]});
            chk("t5_sof_err", {7'd0, sof_err}, 8'd0);
            fd += int'(frame_done);
        end
        step();
        chk("t5_fdone_count", 8'(fd), 8'd1);

        // 6: continuous SOF frames, GAP_CYCLES = 0 vs 3
        k0 = 0; k3 = 0; low0 = 0; low3 = 0; fd0 = 0; fd3 = 0;
        for (int cyc = 0; cyc < 40 && (k0 < 16 || k3 < 16); cyc++) begin
            acc0 = r0 && (k0 < 16);
            acc3 = r3 && (k3 < 16);
            v0 = (k0 < 16); d0 = pat[k0 % 16]; f0 = ((k0 % 8) == 0);
            v3 = (k3 < 16); d3 = pat[k3 % 16]; f3 = ((k3 % 8) == 0);
            step();
            if (acc0) begin
                chk("t6_g0_din", {7'd0, dn0}, {7'd0, pat[k0]});
                chk("t6_g0_sel", {5'd0, c0, b0, a0}, 8'(k0 % 8));
                k0++;
            end else if (k0 < 16) begin
                low0++;
                chk("t6_g0_gap_din", {7'd0, dn0}, 8'd0);
            end else begin
                chk("t6_g0_done_din", {7'd0, dn0}, 8'd0);
            end
            if (acc3) begin
                chk("t6_g3_din", {7'd0, dn3}, {7'd0, pat[k3]});
                chk("t6_g3_sel", {5'd0, c3, b3, a3}, 8'(k3 % 8));
                k3++;
            end else if (k3 < 16) begin
                low3++;
                chk("t6_g3_gap_din", {7'd0, dn3}, 8'd0);
            end else begin
                chk("t6_g3_done_din", {7'd0, dn3}, 8'd0);
            end
            fd0 += int'(fd0_o);
            fd3 += int'(fd3_o);
        end
        v0 = 1'b0; v3 = 1'b0;
        chk("t6_g0_bits", 8'(k0), 8'd16);
        chk("t6_g3_bits", 8'(k3), 8'd16);
        chk("t6_g0_low", 8'(low0), 8'd0);
        chk("t6_g3_low", 8'(low3), 8'd3);
        chk("t6_g0_fdone", 8'(fd0), 8'd2);
        chk("t6_g3_fdone", 8'(fd3), 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
